key_sw_input_dev: RTL and testbench
===================================

// Module: key_sw_input_dev
// PURPOSE
//  Read-side device peripheral: the CPU reads board inputs over the same DEVICE/DATA bus that write-side peripherals use.
//  Synchronises and debounces the 4 active-low pushbuttons, latches press events (read-to-clear) and counts presses.
//  Mirrors the switches and returns the selected register on DATA_out when the CPU issues a read.
//  Sits beside the output devices on the device bus; DATA_out is muxed into the CPU read path, gated by DATA_valid.
// PARAMETERS
//  BASE_ADDR        16'h0040  DEVICE address of register 0; registers at BASE_ADDR+0..+3
//  DEBOUNCE_CYCLES  50000     consecutive stable samples required to accept a key level change (1 ms @ 50 MHz)
//  CNT_W            16        width of the debounce counter; must hold DEBOUNCE_CYCLES
// PORTS
//  clk        in   1   system clock; all state updates on the falling edge
//  rst_n      in   1   asynchronous active-low reset
//  DEVICE     in   16  device address from the CPU
//  RD         in   1   read strobe, sampled together with DEVICE
//  KEY_in     in   4   raw pushbuttons, active-low, asynchronous
//  SW_in      in   10  raw slide switches, asynchronous
//  DATA_out   out  16  read data
//  DATA_valid out  1   one-cycle pulse: DATA_out holds a valid response
//  IRQ        out  1   key-event interrupt (KEY_IRQ_EN builds only)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - DATA_out=0, DATA_valid=0, IRQ=0.
//   - Sync flops and stable key levels = 4'hF (released); event reg=0; press count=0; debounce counters=0.
//   - SW sync flops = 0.
//  Sync: KEY_in and SW_in each pass through 2 flops; all logic below uses the synchronised values only.
//  Debounce, per key:
//   - If the synced level equals the stable level, the counter clears.
//   - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the stable level takes the synced value and the counter clears.
//   - A glitch shorter than DEBOUNCE_CYCLES restarts the count; the stable level does not change.
//  Press event: stable level 1->0 sets evt[i], and press_cnt increments (wraps 16'hFFFF->0).
//   - Multiple keys accepted in the same cycle add their popcount to press_cnt.
//   - Releases (0->1) produce no event.
//  Registers (read-only):
//   - +0 = {6'b0, SW_sync}.
//   - +1 = {12'b0, ~key_stable} (1 = held).
//   - +2 = {12'b0, evt}; a read clears evt (read-to-clear).
//   - +3 = press_cnt.
//  Read handshake:
//   - RD=1 with DEVICE in range at falling edge N: DATA_out loads at edge N and DATA_valid=1 for exactly that cycle.
//   - Back-to-back reads are allowed, one response per cycle.
//   - Out-of-range DEVICE or RD=0: DATA_valid=0; DATA_out holds its last value.
//  Simultaneous read of +2 and a new press in the same cycle:
//   - The returned value excludes the new press.
//   - evt after the edge = new-press bits only; no event is lost.
//  Reset mid-debounce: the counter and the stable level return to reset values; no event is generated.
// CONFIGURATION
//  KEY_IRQ_EN defined:
//   - IRQ is registered = |(evt & irq_mask), with irq_mask reset 4'hF.
//   - irq_mask is written at BASE_ADDR+4 when DEVICE matches with RD=0 (mask=DATA[3:0], DATA a 16-bit input added).
//   - IRQ drops the cycle after the clearing read of +2.
//  KEY_IRQ_EN undefined: no mask register, no DATA input; IRQ tied 0; BASE_ADDR+4 is out of range.
// TESTING (DEBOUNCE_CYCLES=4, BASE_ADDR=16'h0040)
//  1. Reset; read 0x0041, 0x0042, 0x0043 -> 16'h0000 each; DATA_valid one-cycle pulse each.
//  2. SW_in=10'h2A5; wait 3 cycles; read 0x0040 -> 16'h02A5.
//  3. KEY_in[0] low for 3 cycles, then high -> 0x0041=0, 0x0042=0, 0x0043=0 (glitch rejected).
//  4. KEY_in[2] held low 10 cycles -> 0x0041=16'h0004; read 0x0042 -> 16'h0004; second read -> 16'h0000; 0x0043=1.
//  5. Press key1 in the cycle of a 0x0042 read -> that read returns 0; next read returns 16'h0002.
//  6. KEY_IRQ_EN: write mask 4'h1, press key3 -> IRQ=0; press key0 -> IRQ=1; read 0x0042 -> IRQ=0 next cycle.

Source files
------------

// File: rtl/key_sw_input_dev.sv
// Read-side device peripheral: synchronised/debounced pushbuttons, press events and switch mirror on the DEVICE/DATA bus.
// Optional build macro KEY_IRQ_EN adds a maskable key-event interrupt and the DATA write input for the mask.
module key_sw_input_dev #(
  parameter logic [15:0] BASE_ADDR       = 16'h0040,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] DEVICE,
  input  logic        RD,
  input  logic [3:0]  KEY_in,
  input  logic [9:0]  SW_in,
`ifdef KEY_IRQ_EN
  input  logic [15:0] DATA,
`endif
  output logic [15:0] DATA_out,
  output logic        DATA_valid,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       key_s1, key_s2, key_stable, key_stable_nxt, key_fall;
  logic [3:0]       evt, evt_nxt;
  logic [9:0]       sw_s1, sw_s2;
  logic [CNT_W-1:0] db_cnt     [4];
  logic [CNT_W-1:0] db_cnt_nxt [4];
  logic [15:0]      press_cnt, offset, rd_data;
  logic             rd_hit, clr_evt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    key_stable_nxt = key_stable;
    for (int i = 0; i < 4; i++) begin
      db_cnt_nxt[i] = '0;
      if (key_s2[i] != key_stable[i]) begin
        if (db_cnt[i] == CNT_LAST) key_stable_nxt[i] = key_s2[i];
        else                       db_cnt_nxt[i]     = db_cnt[i] + 1'b1;
      end
    end
  end

  // Offset arithmetic wraps, so one unsigned compare covers both range ends.
  assign offset   = DEVICE - BASE_ADDR;
  assign rd_hit   = RD && (offset < 16'd4);
  assign clr_evt  = rd_hit && (offset[1:0] == 2'd2);
  assign key_fall = key_stable & ~key_stable_nxt;
  // A press accepted on the clearing read's edge survives; only older events are cleared.
  assign evt_nxt  = (clr_evt ? 4'h0 : evt) | key_fall;

  always_comb begin
    rd_data = '0;
    case (offset[1:0])
      2'd0: rd_data = {6'b0, sw_s2};
      2'd1: rd_data = {12'b0, ~key_stable};
      2'd2: rd_data = {12'b0, evt};
      2'd3: rd_data = press_cnt;
      default: rd_data = '0;
    endcase
  end

  // All state moves on the falling edge so the CPU's rising-edge bus outputs are settled.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1     <= 4'hF;
      key_s2     <= 4'hF;
      key_stable <= 4'hF;
      sw_s1      <= '0;
      sw_s2      <= '0;
      evt        <= '0;
      press_cnt  <= '0;
      // NOTE: the debounce counters form a tiny array of flops, not a RAM, so they take the async reset too.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      DATA_out   <= '0;
      DATA_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the two-stage synchronisers from collapsing into one flop.
      key_s1     <= KEY_in;
      key_s2     <= key_s1;
      sw_s1      <= SW_in;
      sw_s2      <= sw_s1;
      key_stable <= key_stable_nxt;
      for (int i = 0; i < 4; i++) db_cnt[i] <= db_cnt_nxt[i];
      evt        <= evt_nxt;
      press_cnt  <= press_cnt + 16'($countones(key_fall));
      DATA_valid <= rd_hit;
      if (rd_hit) DATA_out <= rd_data;
    end
  end

`ifdef KEY_IRQ_EN
  localparam logic [15:0] MASK_ADDR = BASE_ADDR + 16'd4;

  logic [3:0] irq_mask;
  logic       unused_data;
  assign unused_data = ^DATA[15:4];

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask <= 4'hF;
      IRQ      <= 1'b0;
    end else begin
      if ((DEVICE == MASK_ADDR) && !RD) irq_mask <= DATA[3:0];
      IRQ <= |(evt & irq_mask);
    end
  end
`else
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_key_sw_input_dev.sv
// Self-checking bench for key_sw_input_dev: directed scenarios plus randomized traffic against a window-based reference model.
`timescale 1ns/1ps
module tb_key_sw_input_dev;

  localparam logic [15:0] BASE = 16'h0040;
  localparam int          DB   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] DEVICE;
  logic        RD;
  logic [3:0]  KEY_in;
  logic [9:0]  SW_in;
  logic [15:0] DATA_out;
  logic        DATA_valid;
  logic        IRQ;
`ifdef KEY_IRQ_EN
  logic [15:0] DATA;
`endif

  int checks   = 0;
  int failures = 0;

  key_sw_input_dev #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .DEVICE(DEVICE), .RD(RD), .KEY_in(KEY_in), .SW_in(SW_in),
`ifdef KEY_IRQ_EN
    .DATA(DATA),
`endif
    .DATA_out(DATA_out), .DATA_valid(DATA_valid), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  // Reference model: a key level is accepted once the last DB samples seen by the logic all disagree with it.
  logic [3:0]  m_r1, m_r2, m_stable, m_evt, m_nst, m_fall;
  logic [9:0]  m_s1, m_s2;
  logic [15:0] m_cnt, m_data, m_off;
  logic        m_valid, m_clr, m_agree;
  logic [3:0]  m_hist[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_r1 = 4'hF; m_r2 = 4'hF; m_stable = 4'hF; m_evt = 4'h0;
      m_s1 = '0; m_s2 = '0; m_cnt = '0; m_data = '0; m_valid = 1'b0;
      m_hist.delete();
    end else begin
      m_off   = DEVICE - BASE;
      m_clr   = 1'b0;
      m_valid = 1'b0;
      if (RD && DEVICE >= BASE && DEVICE <= BASE + 16'd3) begin
        m_valid = 1'b1;
        case (m_off)
          16'd0: m_data = {6'b0, m_s2};
          16'd1: m_data = {12'b0, ~m_stable};
          16'd2: begin m_data = {12'b0, m_evt}; m_clr = 1'b1; end
          default: m_data = m_cnt;
        endcase
      end
      m_hist.push_back(m_r2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      m_nst = m_stable;
      for (int i = 0; i < 4; i++) begin
        if (m_hist.size() == DB) begin
          m_agree = 1'b1;
          foreach (m_hist[j]) if (m_hist[j][i] == m_stable[i]) m_agree = 1'b0;
          if (m_agree) m_nst[i] = ~m_stable[i];
        end
      end
      m_fall   = m_stable & ~m_nst;
      m_evt    = (m_clr ? 4'h0 : m_evt) | m_fall;
      m_cnt    = m_cnt + 16'($countones(m_fall));
      m_stable = m_nst;
      m_r2 = m_r1; m_r1 = KEY_in;
      m_s2 = m_s1; m_s1 = SW_in;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_read(input logic [15:0] addr, output logic [15:0] data, output logic valid);
    DEVICE = addr;
    RD     = 1'b1;
    @(posedge clk);
    data   = DATA_out;
    valid  = DATA_valid;
    RD     = 1'b0;
    DEVICE = 16'h0000;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic        v;
    rst_n = 1'b0;
    DEVICE = 16'h0000; RD = 1'b0; KEY_in = 4'hF; SW_in = '0;
`ifdef KEY_IRQ_EN
    DATA = 16'h000F;
`endif
    repeat (3) @(posedge clk);
    checks++; if (DATA_out !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", DATA_out); end
    checks++; if (DATA_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", DATA_valid); end
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    rst_n = 1'b1;
    @(posedge clk);
    for (int a = 1; a <= 3; a++) begin
      do_read(BASE + 16'(a), d, v);
      checks++; if (v !== 1'b1) begin failures++; $display("FAIL reset_rd_valid addr=%0d got=%b exp=1", a, v); end
      checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_rd_data addr=%0d got=%h exp=0000", a, d); end
      @(posedge clk);
      checks++; if (DATA_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_pulse addr=%0d got=%b exp=0", a, DATA_valid); end
    end
  endtask

  task automatic test_switches();
    logic [15:0] d;
    logic        v;
    SW_in = 10'h2A5;
    repeat (3) @(posedge clk);
    do_read(BASE, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h02A5) begin failures++; $display("FAIL sw_read got=%h/%b exp=02A5/1", d, v); end
  endtask

  task automatic test_glitch();
    logic [15:0] d;
    logic        v;
    KEY_in = 4'b1110;
    repeat (3) @(posedge clk);
    KEY_in = 4'hF;
    repeat (8) @(posedge clk);
    for (int a = 1; a <= 3; a++) begin
      do_read(BASE + 16'(a), d, v);
      checks++; if (d !== 16'h0000) begin failures++; $display("FAIL glitch_rd addr=%0d got=%h exp=0000", a, d); end
    end
  endtask

  task automatic test_press();
    logic [15:0] d;
    logic        v;
    KEY_in = 4'b1011;
    repeat (10) @(posedge clk);
    do_read(BASE + 16'd1, d, v);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL press_held got=%h exp=0004", d); end
    do_read(BASE + 16'd2, d, v);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL press_evt got=%h exp=0004", d); end
    do_read(BASE + 16'd2, d, v);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL press_evt_cleared got=%h exp=0000", d); end
    do_read(BASE + 16'd3, d, v);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL press_cnt got=%h exp=0001", d); end
    KEY_in = 4'hF;
    repeat (8) @(posedge clk);
    do_read(BASE + 16'd2, d, v);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL release_no_evt got=%h exp=0000", d); end
  endtask

  task automatic test_read_clear_race();
    logic [15:0] d;
    logic        v;
    // Key1 goes low now; its acceptance edge lands on the read issued five edges later.
    KEY_in = 4'b1101;
    repeat (5) @(posedge clk);
    do_read(BASE + 16'd2, d, v);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL race_first got=%h exp=0000", d); end
    do_read(BASE + 16'd2, d, v);
    checks++; if (d !== 16'h0002) begin failures++; $display("FAIL race_second got=%h exp=0002", d); end
    KEY_in = 4'hF;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_b2b [4];
    exp_b2b[0] = 16'h02A5; exp_b2b[1] = 16'h0000; exp_b2b[2] = 16'h0000; exp_b2b[3] = 16'h0002;
    RD = 1'b1;
    for (int a = 0; a < 4; a++) begin
      DEVICE = BASE + 16'(a);
      @(posedge clk);
      checks++;
      if (DATA_valid !== 1'b1 || DATA_out !== exp_b2b[a]) begin
        failures++; $display("FAIL b2b addr=%0d got=%h/%b exp=%h/1", a, DATA_out, DATA_valid, exp_b2b[a]);
      end
    end
    DEVICE = BASE + 16'd4;
    @(posedge clk);
    checks++; if (DATA_valid !== 1'b0 || DATA_out !== 16'h0002) begin failures++; $display("FAIL oor_high got=%h/%b exp=0002/0", DATA_out, DATA_valid); end
    DEVICE = BASE - 16'd1;
    @(posedge clk);
    checks++; if (DATA_valid !== 1'b0 || DATA_out !== 16'h0002) begin failures++; $display("FAIL oor_low got=%h/%b exp=0002/0", DATA_out, DATA_valid); end
    RD = 1'b0;
    DEVICE = BASE;
    @(posedge clk);
    checks++; if (DATA_valid !== 1'b0 || DATA_out !== 16'h0002) begin failures++; $display("FAIL rd_low got=%h/%b exp=0002/0", DATA_out, DATA_valid); end
    DEVICE = 16'h0000;
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    logic        v;
    KEY_in = 4'b1110;
    repeat (4) @(posedge clk);
    rst_n = 1'b0;
    KEY_in = 4'hF;
    repeat (2) @(posedge clk);
    checks++; if (DATA_out !== 16'h0000) begin failures++; $display("FAIL midrst_data got=%h exp=0000", DATA_out); end
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    do_read(BASE + 16'd2, d, v);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midrst_evt got=%h exp=0000", d); end
    do_read(BASE + 16'd3, d, v);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midrst_cnt got=%h exp=0000", d); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(5) == 0) KEY_in = 4'($urandom);
      if ($urandom_range(15) == 0) SW_in = 10'($urandom);
      RD     = 1'($urandom);
      DEVICE = BASE - 16'd2 + 16'($urandom_range(7));
      @(posedge clk);
      checks++;
      if (DATA_valid !== m_valid || DATA_out !== m_data) begin
        failures++; $display("FAIL random n=%0d got=%h/%b exp=%h/%b", n, DATA_out, DATA_valid, m_data, m_valid);
      end
    end
    RD = 1'b0; DEVICE = 16'h0000; KEY_in = 4'hF;
    repeat (8) @(posedge clk);
  endtask

`ifdef KEY_IRQ_EN
  task automatic test_irq();
    logic [15:0] d;
    logic        v;
    do_read(BASE + 16'd2, d, v);
    repeat (2) @(posedge clk);
    DEVICE = BASE + 16'd4; RD = 1'b0; DATA = 16'h0001;
    @(posedge clk);
    DEVICE = 16'h0000; DATA = 16'h000F;
    KEY_in = 4'b0111;
    repeat (8) @(posedge clk);
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", IRQ); end
    KEY_in = 4'hF;
    repeat (8) @(posedge clk);
    KEY_in = 4'b1110;
    repeat (8) @(posedge clk);
    checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", IRQ); end
    KEY_in = 4'hF;
    repeat (8) @(posedge clk);
    do_read(BASE + 16'd2, d, v);
    checks++; if (d !== 16'h0009) begin failures++; $display("FAIL irq_evt got=%h exp=0009", d); end
    @(posedge clk);
    checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", IRQ); end
  endtask
`endif

  initial begin
    test_reset();
    test_switches();
    test_glitch();
    test_press();
    test_read_clear_race();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef KEY_IRQ_EN
    test_irq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
